// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM state type,
// stall-length rule and the decoder opcode constants it relies on.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HOLD  = 2'd2
    } hz_state_t;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LWU = 6'h27;

    // Longest stall demanded by any producer the ID instruction depends on.
    function automatic logic [2:0] stall_len(
        input logic [1:0] load_lat,
        input logic       is_branch,
        input logic       ex_load_hit,
        input logic       ex_alu_hit,
        input logic       mem_load_hit
    );
        logic [2:0] n;
        n = 3'd0;
        if (ex_load_hit) begin
            n = is_branch ? ({1'b0, load_lat} + 3'd1) : {1'b0, load_lat};
        end
        if (is_branch && ex_alu_hit && (n < 3'd1)) begin
            n = 3'd1;
        end
        if (is_branch && mem_load_hit && (n < {1'b0, load_lat})) begin
            n = {1'b0, load_lat};
        end
        return n;
    endfunction

endpackage

// File: rtl/hazard_stall_timer.sv
// Loadable down-counter that stops at zero; freeze holds the value unchanged.
module hazard_stall_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         freeze,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (freeze) begin
            count_d = count_q;
        end else if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch-in-ID hazard controller with timed stalls, IF/ID flush and
// external freeze. Define HAZARD_PERF_CNT_EN to build the saturating perf counters.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_is_branch,
    input  logic              id_is_jump,
    input  logic              br_taken,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              mem_mem_read,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              ext_hold,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ctrl_stall,
    output logic              ifid_flush,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_events
);

    if ((LOAD_LAT < 1) || (LOAD_LAT > 3)) begin : g_bad_load_lat
        $fatal(1, "hazard_stall_ctrl: LOAD_LAT must be 1..3");
    end

    localparam int         TW    = $clog2(LOAD_LAT + 2);
    localparam logic [1:0] LAT_L = 2'(LOAD_LAT);

    hz_state_t state_q, state_d;
    hz_state_t saved_q, saved_d;
    hz_state_t cur_state;
    logic      stall_active;
    logic      tmr_load;
    logic      tmr_zero;
    logic [2:0] n_raw;
    logic [2:0] n_need;
    logic [TW-1:0] tmr_load_val;

    // A load in MEM is identified by mem_mem_read alone; its write flag adds nothing.
    logic unused_mem_reg_write;
    assign unused_mem_reg_write = mem_reg_write;

    logic rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit;
    logic ex_load_hit, ex_alu_hit, mem_load_hit;

    assign rs_ex_hit  = id_use_rs && (id_rs == ex_dst)  && (id_rs != '0);
    assign rt_ex_hit  = id_use_rt && (id_rt == ex_dst)  && (id_rt != '0);
    assign rs_mem_hit = id_use_rs && (id_rs == mem_dst) && (id_rs != '0);
    assign rt_mem_hit = id_use_rt && (id_rt == mem_dst) && (id_rt != '0);

    assign ex_load_hit  = ex_mem_read && (rs_ex_hit || rt_ex_hit);
    assign ex_alu_hit   = ex_reg_write && !ex_mem_read && (rs_ex_hit || rt_ex_hit);
    assign mem_load_hit = mem_mem_read && (rs_mem_hit || rt_mem_hit);

    assign n_raw = stall_len(LAT_L, id_is_branch, ex_load_hit, ex_alu_hit, mem_load_hit);

    // A drained timer means the stall is over even before state_q returns to RUN.
    assign cur_state    = (state_q == HOLD) ? saved_q : state_q;
    assign stall_active = (cur_state == STALL) && !tmr_zero;
    assign n_need       = stall_active ? 3'd0 : n_raw;
    assign tmr_load_val = TW'(n_need - 3'd1);

    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        tmr_load = 1'b0;
        if (ext_hold) begin
            state_d = HOLD;
            saved_d = cur_state;
        end else if (stall_active) begin
            state_d = STALL;
        end else if (n_need != 3'd0) begin
            state_d  = STALL;
            tmr_load = 1'b1;
        end else begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            saved_q <= RUN;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
        end
    end

    hazard_stall_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .freeze   (ext_hold),
        .load_val (tmr_load_val),
        .zero     (tmr_zero)
    );

    // Reset forces the enables open combinationally, even with a hazard on the inputs.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ctrl_stall = 1'b0;
        ifid_flush = 1'b0;
        if (!rst_n) begin
            pc_write = 1'b1;
        end else if (ext_hold) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (stall_active || (n_need != 3'd0)) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ctrl_stall = 1'b1;
        end else if (id_is_jump || (id_is_branch && br_taken)) begin
            ifid_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [PERF_W-1:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (ctrl_stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
        if (ifid_flush && (flush_events_q != '1)) begin
            flush_events_d = flush_events_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: two instances (LOAD_LAT=1 and LOAD_LAT=2
// with 3-bit counters) share one stimulus; outputs are compared to hand-derived values.
module tb_hazard_stall_ctrl;

    localparam logic [3:0] O_RUN   = 4'b1100;  // {pc_write, ifid_write, ctrl_stall, ifid_flush}
    localparam logic [3:0] O_STALL = 4'b0010;
    localparam logic [3:0] O_HOLD  = 4'b0000;
    localparam logic [3:0] O_FLUSH = 4'b1101;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_dst, mem_dst;
    logic       id_use_rs, id_use_rt, id_is_branch, id_is_jump, br_taken;
    logic       ex_mem_read, ex_reg_write, mem_mem_read, mem_reg_write, ext_hold;

    logic        pc1, ifid1, stall1, flush1;
    logic [31:0] sc1, fe1;
    logic        pc2, ifid2, stall2, flush2;
    logic [2:0]  sc2, fe2;

    logic [3:0] o1, o2;
    assign o1 = {pc1, ifid1, stall1, flush1};
    assign o2 = {pc2, ifid2, stall2, flush2};

    int checks = 0;
    int errors = 0;

    hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .PERF_W(32)) u_lat1 (
        .clk (clk), .rst_n (rst_n),
        .id_rs (id_rs), .id_rt (id_rt), .id_use_rs (id_use_rs), .id_use_rt (id_use_rt),
        .id_is_branch (id_is_branch), .id_is_jump (id_is_jump), .br_taken (br_taken),
        .ex_mem_read (ex_mem_read), .ex_reg_write (ex_reg_write), .ex_dst (ex_dst),
        .mem_mem_read (mem_mem_read), .mem_reg_write (mem_reg_write), .mem_dst (mem_dst),
        .ext_hold (ext_hold),
        .pc_write (pc1), .ifid_write (ifid1), .ctrl_stall (stall1), .ifid_flush (flush1),
        .stall_cycles (sc1), .flush_events (fe1)
    );

    hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(2), .PERF_W(3)) u_lat2 (
        .clk (clk), .rst_n (rst_n),
        .id_rs (id_rs), .id_rt (id_rt), .id_use_rs (id_use_rs), .id_use_rt (id_use_rt),
        .id_is_branch (id_is_branch), .id_is_jump (id_is_jump), .br_taken (br_taken),
        .ex_mem_read (ex_mem_read), .ex_reg_write (ex_reg_write), .ex_dst (ex_dst),
        .mem_mem_read (mem_mem_read), .mem_reg_write (mem_reg_write), .mem_dst (mem_dst),
        .ext_hold (ext_hold),
        .pc_write (pc2), .ifid_write (ifid2), .ctrl_stall (stall2), .ifid_flush (flush2),
        .stall_cycles (sc2), .flush_events (fe2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       ex_ld;
        logic       ex_alu;
        logic [4:0] ex_d;
        logic       mem_ld;
        logic [4:0] mem_d;
        logic [4:0] rs;
        logic       use_rs;
        logic [4:0] rt;
        logic       use_rt;
        logic       br;
        logic [2:0] len1;
        logic [2:0] len2;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_is_branch = 1'b0; id_is_jump = 1'b0; br_taken = 1'b0;
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dst = '0;
        mem_mem_read = 1'b0; mem_reg_write = 1'b0; mem_dst = '0;
        ext_hold = 1'b0;
    endtask

    task automatic bubble_back();
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dst = '0;
        mem_mem_read = 1'b0; mem_reg_write = 1'b0; mem_dst = '0;
    endtask

    task automatic settle();
        idle();
        repeat (4) tick();
    endtask

    task automatic apply_vec(input vec_t v);
        ex_mem_read  = v.ex_ld;
        ex_reg_write = v.ex_ld | v.ex_alu;
        ex_dst       = v.ex_d;
        mem_mem_read = v.mem_ld;
        mem_reg_write = v.mem_ld;
        mem_dst      = v.mem_d;
        id_rs = v.rs; id_use_rs = v.use_rs;
        id_rt = v.rt; id_use_rt = v.use_rt;
        id_is_branch = v.br;
        br_taken     = 1'b0;
    endtask

    // EX load to r9 feeding an untaken branch: 2 stall cycles at LAT=1, 3 at LAT=2.
    task automatic branch_load_stall();
        settle();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd9;
        id_rt = 5'd9; id_use_rt = 1'b1; id_is_branch = 1'b1;
        tick();
        bubble_back();
        repeat (5) tick();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (o1 !== O_RUN) begin errors++; $display("FAIL reset_out_lat1: got %b want %b", o1, O_RUN); end
        checks++;
        if (o2 !== O_RUN) begin errors++; $display("FAIL reset_out_lat2: got %b want %b", o2, O_RUN); end
        checks++;
        if ({sc1, fe1, sc2, fe2} !== '0) begin
            errors++; $display("FAIL reset_counters: got %0d %0d %0d %0d want 0", sc1, fe1, sc2, fe2);
        end
        #20 rst_n = 1'b1;
        tick();
        checks++;
        if (o1 !== O_RUN) begin errors++; $display("FAIL post_reset_run: got %b want %b", o1, O_RUN); end
    endtask

    task automatic test_load_use();
        settle();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd8;
        id_rs = 5'd8; id_use_rs = 1'b1;
        #1;
        checks++;
        if (o1 !== O_STALL) begin errors++; $display("FAIL load_use_c0: got %b want %b", o1, O_STALL); end
        tick();
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dst = '0;
        mem_mem_read = 1'b1; mem_reg_write = 1'b1; mem_dst = 5'd8;
        #1;
        checks++;
        if (o1 !== O_RUN) begin errors++; $display("FAIL load_use_c1: got %b want %b", o1, O_RUN); end
        tick();
        bubble_back();
        #1;
        checks++;
        if (o1 !== O_RUN) begin errors++; $display("FAIL load_use_c2: got %b want %b", o1, O_RUN); end
    endtask

    task automatic test_branch_flush();
        settle();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd9;
        id_rs = 5'd9; id_use_rs = 1'b1; id_is_branch = 1'b1; br_taken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_dst = '0;
                mem_mem_read = 1'b1; mem_reg_write = 1'b1; mem_dst = 5'd9;
            end
            if (k == 2) bubble_back();
            #1;
            checks++;
            if (o2 !== O_STALL) begin errors++; $display("FAIL br_stall_c%0d: got %b want %b", k, o2, O_STALL); end
            tick();
        end
        #1;
        checks++;
        if (o2 !== O_FLUSH) begin errors++; $display("FAIL br_flush: got %b want %b", o2, O_FLUSH); end
        tick();
        id_is_branch = 1'b0; br_taken = 1'b0; id_use_rs = 1'b0;
        #1;
        checks++;
        if (o2 !== O_RUN) begin errors++; $display("FAIL br_after_flush: got %b want %b", o2, O_RUN); end
    endtask

    task automatic test_zero_reg_jump();
        settle();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = '0;
        id_rs = '0; id_use_rs = 1'b1;
        #1;
        checks++;
        if ({o1, o2} !== {O_RUN, O_RUN}) begin
            errors++; $display("FAIL zero_reg: got %b/%b want %b", o1, o2, O_RUN);
        end
        id_is_jump = 1'b1;
        #1;
        checks++;
        if ({o1, o2} !== {O_FLUSH, O_FLUSH}) begin
            errors++; $display("FAIL jump_flush: got %b/%b want %b", o1, o2, O_FLUSH);
        end
        tick();
        id_is_jump = 1'b0;
        #1;
        checks++;
        if (o1 !== O_RUN) begin errors++; $display("FAIL jump_one_cycle: got %b want %b", o1, O_RUN); end
    endtask

    task automatic test_rules();
        vec_t vecs[10];
        int   l1, l2;
        //          ex_ld ex_alu ex_d  mem_ld mem_d rs    urs  rt    urt  br   len1  len2
        vecs[0] = '{1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 3'd1, 3'd2};
        vecs[1] = '{1'b1, 1'b0, 5'd9, 1'b0, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 3'd2, 3'd3};
        vecs[2] = '{1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 3'd1, 3'd1};
        vecs[3] = '{1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 3'd0, 3'd0};
        vecs[4] = '{1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 3'd1, 3'd2};
        vecs[5] = '{1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 3'd0, 3'd0};
        vecs[6] = '{1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 3'd0};
        vecs[7] = '{1'b1, 1'b0, 5'd3, 1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 3'd2, 3'd3};
        vecs[8] = '{1'b0, 1'b1, 5'd4, 1'b1, 5'd6, 5'd4, 1'b1, 5'd6, 1'b1, 1'b1, 3'd1, 3'd2};
        vecs[9] = '{1'b1, 1'b0, 5'd2, 1'b0, 5'd0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 3'd0, 3'd0};
        for (int i = 0; i < 10; i++) begin
            settle();
            apply_vec(vecs[i]);
            l1 = 0;
            l2 = 0;
            for (int k = 0; k < 8; k++) begin
                #1;
                if (stall1) l1++;
                if (stall2) l2++;
                tick();
                if (k == 0) bubble_back();
            end
            checks++;
            if (l1 != int'(vecs[i].len1)) begin
                errors++; $display("FAIL rule%0d_len_lat1: got %0d want %0d", i, l1, vecs[i].len1);
            end
            checks++;
            if (l2 != int'(vecs[i].len2)) begin
                errors++; $display("FAIL rule%0d_len_lat2: got %0d want %0d", i, l2, vecs[i].len2);
            end
        end
    endtask

    task automatic test_hold();
        settle();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd9;
        id_rs = 5'd9; id_use_rs = 1'b1; id_is_branch = 1'b1;
        #1;
        checks++;
        if (o2 !== O_STALL) begin errors++; $display("FAIL hold_pre_stall: got %b want %b", o2, O_STALL); end
        tick();
        bubble_back();
        ext_hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (o2 !== O_HOLD) begin errors++; $display("FAIL hold_c%0d: got %b want %b", k, o2, O_HOLD); end
            tick();
        end
        ext_hold = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (o2 !== O_STALL) begin errors++; $display("FAIL hold_resume_c%0d: got %b want %b", k, o2, O_STALL); end
            tick();
        end
        #1;
        checks++;
        if (o2 !== O_RUN) begin errors++; $display("FAIL hold_end: got %b want %b", o2, O_RUN); end
    endtask

    task automatic test_reset_mid_stall();
        int l2;
        settle();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd9;
        id_rs = 5'd9; id_use_rs = 1'b1; id_is_branch = 1'b1;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o1, o2} !== {O_RUN, O_RUN}) begin
            errors++; $display("FAIL rst_mid_stall: got %b/%b want %b", o1, o2, O_RUN);
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (o2 !== O_STALL) begin errors++; $display("FAIL rst_restall_c0: got %b want %b", o2, O_STALL); end
        l2 = 1;
        tick();
        bubble_back();
        for (int k = 0; k < 6; k++) begin
            #1;
            if (stall2) l2++;
            tick();
        end
        checks++;
        if (l2 != 3) begin errors++; $display("FAIL rst_restall_len: got %0d want 3", l2); end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_counters();
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        branch_load_stall();
        branch_load_stall();
        settle();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dst = 5'd8;
        id_rs = 5'd8; id_use_rs = 1'b1;
        tick();
        bubble_back();
        repeat (3) tick();
        for (int j = 0; j < 2; j++) begin
            settle();
            id_is_jump = 1'b1;
            tick();
            id_is_jump = 1'b0;
        end
        settle();
        checks++;
        if (sc1 !== 32'd5) begin errors++; $display("FAIL perf_stall_cycles: got %0d want 5", sc1); end
        checks++;
        if (fe1 !== 32'd2) begin errors++; $display("FAIL perf_flush_events: got %0d want 2", fe1); end
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        repeat (3) branch_load_stall();
        settle();
        checks++;
        if (sc2 !== 3'd7) begin errors++; $display("FAIL perf_saturate: got %0d want 7", sc2); end
        checks++;
        if (sc1 !== 32'd6) begin errors++; $display("FAIL perf_lat1_count: got %0d want 6", sc1); end
        checks++;
        if (fe2 !== 3'd0) begin errors++; $display("FAIL perf_no_flush: got %0d want 0", fe2); end
    endtask
`else
    task automatic test_perf_counters();
        branch_load_stall();
        settle();
        id_is_jump = 1'b1;
        tick();
        settle();
        checks++;
        if ({sc1, fe1} !== '0) begin errors++; $display("FAIL perf_off_lat1: got %0d %0d want 0", sc1, fe1); end
        checks++;
        if ({sc2, fe2} !== '0) begin errors++; $display("FAIL perf_off_lat2: got %0d %0d want 0", sc2, fe2); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_branch_flush();
        test_zero_reg_jump();
        test_rules();
        test_hold();
        test_reset_mid_stall();
        test_perf_counters();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
